// File: rtl/rot_enc_emulator.sv
// rot_enc_emulator: command-driven quadrature (A/B) and active-low pushbutton waveform generator.
// Registered outputs follow the FSM by one cycle, so waveforms start on the edge after accept.
module rot_enc_emulator #(
    parameter int PHASE_CYC  = 4,
    parameter int GLITCH_CYC = 20,
    parameter int SHORT_CYC  = 200,
    parameter int NORMAL_CYC = 800,
    parameter int LONG_CYC   = 2000,
    parameter int GAP_CYC    = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_kind_i,
    input  logic       cmd_dir_i,
    input  logic [3:0] cmd_count_i,
    input  logic [1:0] cmd_press_i,
    input  logic       abort_i,
    output logic       a_o,
    output logic       b_o,
    output logic       pb_o,
    output logic       busy_o,
    output logic       done_o
);
    if (PHASE_CYC < 1 || PHASE_CYC > 4095 || GAP_CYC < 1 || GAP_CYC > 4095 ||
        GLITCH_CYC < 1 || GLITCH_CYC > 4095 || SHORT_CYC < 1 || SHORT_CYC > 4095 ||
        NORMAL_CYC < 1 || NORMAL_CYC > 4095 || LONG_CYC < 1 || LONG_CYC > 4095) begin : g_bad_param
        $error("rot_enc_emulator: timing parameter outside 1..4095");
    end
    localparam logic [11:0] PH_LD  = 12'(PHASE_CYC - 1);
    localparam logic [11:0] GAP_LD = 12'(GAP_CYC - 1);
    localparam logic [11:0] GL_LD  = 12'(GLITCH_CYC - 1);
    localparam logic [11:0] SH_LD  = 12'(SHORT_CYC - 1);
    localparam logic [11:0] NO_LD  = 12'(NORMAL_CYC - 1);
    localparam logic [11:0] LO_LD  = 12'(LONG_CYC - 1);
    typedef enum logic [1:0] {IDLE, ROT, PRESS, GAP} state_t;
    state_t      state_q, state_d;
    logic [11:0] tmr_q, tmr_d;
    logic [3:0]  det_q, det_d;
    logic [1:0]  ph_q, ph_d;
    logic        dir_q, dir_d;
    logic        a_d, b_d, pb_d, busy_d, done_d, rdy_d;
    logic        a_q, b_q, pb_q, busy_q, done_q, rdy_q;
    logic        accept, rot_act;
    logic [11:0] press_ld;
    assign accept   = cmd_valid_i & rdy_q;
    assign press_ld = cmd_press_i == 2'd0 ? GL_LD :
                      cmd_press_i == 2'd1 ? SH_LD :
                      cmd_press_i == 2'd2 ? NO_LD : LO_LD;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            det_q   <= '0;
            ph_q    <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pb_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            det_q   <= det_d;
            ph_q    <= ph_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pb_q    <= pb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        det_d   = det_q;
        ph_d    = ph_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (accept) begin
                dir_d = cmd_dir_i;
                det_d = cmd_count_i;
                ph_d  = 2'd0;
                if (cmd_kind_i) begin
                    state_d = PRESS;
                    tmr_d   = press_ld;
                end else if (cmd_count_i == 4'd0) begin
                    state_d = GAP;
                    tmr_d   = GAP_LD;
                end else begin
                    state_d = ROT;
                    tmr_d   = PH_LD;
                end
            end
            ROT: if (abort_i) begin
                state_d = GAP;
                tmr_d   = GAP_LD;
            end else if (tmr_q != 12'd0) begin
                tmr_d = tmr_q - 12'd1;
            end else begin
                ph_d  = ph_q + 2'd1;
                tmr_d = PH_LD;
                // detent completes when the fourth phase (back at 00) expires
                if (ph_q == 2'd3) begin
                    det_d = det_q - 4'd1;
                    if (det_q == 4'd1) begin
                        state_d = GAP;
                        tmr_d   = GAP_LD;
                    end
                end
            end
            PRESS: if (abort_i || tmr_q == 12'd0) begin
                state_d = GAP;
                tmr_d   = GAP_LD;
            end else begin
                tmr_d = tmr_q - 12'd1;
            end
            GAP: if (tmr_q == 12'd0) begin
                state_d = IDLE;
            end else begin
                tmr_d = tmr_q - 12'd1;
            end
        endcase
    end
    // CW phases 10,11,01,00; CCW swaps the channels. abort idles outputs at once.
    always_comb begin
        rot_act = state_q == ROT && !abort_i;
        a_d     = rot_act && (dir_q ? (ph_q[0] ^ ph_q[1]) : ~ph_q[1]);
        b_d     = rot_act && (dir_q ? ~ph_q[1] : (ph_q[0] ^ ph_q[1]));
        pb_d    = !(state_q == PRESS && !abort_i);
        busy_d  = state_q != IDLE;
        rdy_d   = state_q == IDLE && !accept;
        done_d  = state_q == IDLE && !rdy_q;
    end
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign pb_o        = pb_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cmd_ready_o = rdy_q;
endmodule

// File: tb/tb_rot_enc_emulator.sv
// tb_rot_enc_emulator: directed bench with a reference quadrature/press decoder model.
module tb_rot_enc_emulator;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_kind = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [3:0] cmd_count = '0;
    logic [1:0] cmd_press = '0;
    logic       cmd_ready, a, b, pb, busy, done;
    int checks = 0, errors = 0;
    int enc = 0, ab_edges = 0, pb_run = 0, pb_last = 0;
    logic [1:0] ab_prev = 2'b00;
    logic       pb_prev = 1'b1;

    rot_enc_emulator dut (
        .clk(clk), .rstn(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_kind_i(cmd_kind), .cmd_dir_i(cmd_dir), .cmd_count_i(cmd_count),
        .cmd_press_i(cmd_press), .abort_i(abort), .a_o(a), .b_o(b), .pb_o(pb),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // decoder model: one count per detent, on return to 00 (from 01 => CW, from 10 => CCW)
    always @(negedge clk) begin
        if ({a, b} != ab_prev) ab_edges++;
        if ({a, b} == 2'b00 && ab_prev == 2'b01) enc++;
        if ({a, b} == 2'b00 && ab_prev == 2'b10) enc--;
        ab_prev = {a, b};
        if (!pb) pb_run++;
        if (pb && !pb_prev) begin
            pb_last = pb_run;
            pb_run = 0;
        end
        pb_prev = pb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic kind, input logic dir, input logic [3:0] cnt, input logic [1:0] pr);
        cmd_valid = 1'b1; cmd_kind = kind; cmd_dir = dir; cmd_count = cnt; cmd_press = pr;
        tick();
        cmd_valid = 1'b0; cmd_kind = ~kind; cmd_dir = ~dir; cmd_count = ~cnt; cmd_press = ~pr;
        chk("ready_drop", 32'(cmd_ready), 0);
    endtask

    task automatic wait_done(output int n, output int busy_low);
        n = 0;
        busy_low = 0;
        do begin
            tick();
            n++;
            if (!done && !busy) busy_low++;
        end while (!done && n < 5000);
    endtask

    initial begin
        int n, bl, e0, x0;
        logic [1:0] cw [4];
        int press_len [4];
        cw[0] = 2'b10; cw[1] = 2'b11; cw[2] = 2'b01; cw[3] = 2'b00;
        press_len[0] = 20; press_len[1] = 200; press_len[2] = 800; press_len[3] = 2000;
        repeat (3) tick();
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_pb", 32'(pb), 1);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rstn = 1'b1;
        tick();

        // CW x3: A leads, 4 cycles per phase, first edge one cycle after accept
        e0 = enc;
        issue(1'b0, 1'b0, 4'd3, 2'd0);
        chk("cw_no_edge_at_accept", 32'({a, b}), 0);
        chk("cw_busy_at_accept", 32'(busy), 0);
        for (int k = 1; k <= 48; k++) begin
            tick();
            chk($sformatf("cw_ab_%0d", k), 32'({a, b}), 32'(cw[((k - 1) / 4) % 4]));
        end
        wait_done(n, bl);
        chk("cw_dur", 32'(n + 48), 59);
        chk("cw_enc", 32'(enc - e0), 3);
        chk("cw_ready_with_done", 32'(cmd_ready), 1);
        tick();
        chk("cw_done_one_cycle", 32'(done), 0);

        // CCW x15: B leads A, busy held throughout
        e0 = enc;
        issue(1'b0, 1'b1, 4'd15, 2'd0);
        tick();
        chk("ccw_first_phase", 32'({a, b}), 32'(2'b01));
        chk("ccw_busy", 32'(busy), 1);
        wait_done(n, bl);
        chk("ccw_dur", 32'(n + 1), 251);
        chk("ccw_enc", 32'(enc - e0), -15);
        chk("ccw_busy_never_low", 32'(bl), 0);

        // press classes 0..3, issued back-to-back in each done cycle
        for (int c = 0; c < 4; c++) begin
            issue(1'b1, 1'b0, 4'd0, 2'(c));
            chk($sformatf("press%0d_pb_low_start", c), 32'(pb), 1);
            tick();
            chk($sformatf("press%0d_pb_low", c), 32'(pb), 0);
            wait_done(n, bl);
            chk($sformatf("press%0d_dur", c), 32'(n + 1), 32'(1 + press_len[c] + 10));
            chk($sformatf("press%0d_low_len", c), 32'(pb_last), 32'(press_len[c]));
            chk($sformatf("press%0d_class", c), 32'(pb_last < 50 ? 0 : pb_last < 400 ? 1 :
                                                   pb_last < 1200 ? 2 : 3), 32'(c));
            chk($sformatf("press%0d_ready", c), 32'(cmd_ready), 1);
        end
        tick();

        // zero-detent rotate with abort held: abort ignored in IDLE and GAP
        x0 = ab_edges;
        abort = 1'b1;
        issue(1'b0, 1'b0, 4'd0, 2'd0);
        wait_done(n, bl);
        abort = 1'b0;
        chk("zero_dur", 32'(n), 11);
        chk("zero_no_ab", 32'(ab_edges - x0), 0);
        tick();

        // abort during 2nd detent of a 5-detent rotate
        e0 = enc;
        issue(1'b0, 1'b0, 4'd5, 2'd0);
        repeat (20) tick();
        chk("abort_pre_ab", 32'({a, b}), 32'(2'b10));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_ab", 32'({a, b}), 0);
        chk("abort_busy", 32'(busy), 1);
        wait_done(n, bl);
        chk("abort_dur", 32'(n + 21), 32);
        chk("abort_enc_le2", 32'((enc - e0) <= 2), 1);

        // reset mid-press, then immediate new command
        tick();
        issue(1'b1, 1'b0, 4'd0, 2'd3);
        repeat (100) tick();
        chk("rst_mid_pb_low", 32'(pb), 0);
        rstn = 1'b0;
        tick();
        chk("rst_mid_pb", 32'(pb), 1);
        chk("rst_mid_ready", 32'(cmd_ready), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        rstn = 1'b1;
        issue(1'b0, 1'b0, 4'd1, 2'd0);
        wait_done(n, bl);
        chk("post_rst_dur", 32'(n), 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
